// File: rtl/term_writer_if.sv
// Character input handshake and screen RAM write port
// for the text terminal writer.
interface term_writer_if;
  logic [7:0]  char_i;
  logic        char_valid_i;
  logic        char_ready_o;
  logic        wr_allow_i;
  logic [11:0] wr_addr_o;
  logic [7:0]  wr_data_o;
  logic        wr_en_o;
  logic [6:0]  cursor_col_o;
  logic [4:0]  cursor_row_o;
  logic        busy_o;

  modport master (
    output char_i, char_valid_i, wr_allow_i,
    input  char_ready_o, wr_addr_o, wr_data_o,
    input  wr_en_o, cursor_col_o, cursor_row_o, busy_o
  );

  modport slave (
    input  char_i, char_valid_i, wr_allow_i,
    output char_ready_o, wr_addr_o, wr_data_o,
    output wr_en_o, cursor_col_o, cursor_row_o, busy_o
  );
endinterface

// File: rtl/term_writer.sv
// Text terminal writer: turns a character stream into screen RAM
// writes, with cursor tracking, CR/LF/BS/FF handling and scrolling clears.
module term_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 25
) (
  input logic          clk,
  input logic          rst_n_i,
  term_writer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, PUT, CLR_ROW, CLR_ALL
  } state_t;

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [7:0] SPACE    = 8'h20;

  state_t      state, state_nx;
  logic [6:0]  col;
  logic [4:0]  row;
  logic [11:0] addr;
  logic [7:0]  data;
  logic        bs;
  logic        take;
  logic        is_prn, is_cr, is_lf, is_bs, is_ff;
  logic [6:0]  a_col;
  logic [4:0]  a_row;

  assign a_row = addr[11:7];
  assign a_col = addr[6:0];
  assign take  = bus.char_valid_i && (state == IDLE);

  assign is_prn = (bus.char_i >= 8'h20) && (bus.char_i <= 8'h7E);
  assign is_cr  = (bus.char_i == 8'h0D);
  assign is_lf  = (bus.char_i == 8'h0A);
  assign is_bs  = (bus.char_i == 8'h08);
  assign is_ff  = (bus.char_i == 8'h0C);

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (take) begin
          unique case (1'b1)
            is_prn:  state_nx = PUT;
            is_lf:   if (row == LAST_ROW) state_nx = CLR_ROW;
            is_bs:   if (col != 7'd0) state_nx = PUT;
            is_ff:   state_nx = CLR_ALL;
            default: ;
          endcase
        end
      end
      PUT: begin
        if (bus.wr_allow_i) begin
          if (!bs && col == LAST_COL && row == LAST_ROW)
            state_nx = CLR_ROW;
          else
            state_nx = IDLE;
        end
      end
      CLR_ROW: begin
        if (bus.wr_allow_i && a_col == LAST_COL)
          state_nx = IDLE;
      end
      CLR_ALL: begin
        if (bus.wr_allow_i && a_col == LAST_COL
            && a_row == LAST_ROW)
          state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.char_ready_o = (state == IDLE);
    bus.busy_o       = (state != IDLE);
    bus.wr_en_o      = (state != IDLE) && bus.wr_allow_i;
  end

  // addr doubles as the walk pointer during clears
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
      data <= '0;
      bs   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            unique case (1'b1)
              is_prn: begin
                addr <= {row, col};
                data <= bus.char_i;
                bs   <= 1'b0;
              end
              is_cr: col <= '0;
              is_lf: begin
                col <= '0;
                if (row == LAST_ROW) begin
                  row  <= '0;
                  addr <= '0;
                  data <= SPACE;
                end else begin
                  row <= row + 5'd1;
                end
              end
              is_bs: begin
                if (col != 7'd0) begin
                  addr <= {row, col - 7'd1};
                  data <= SPACE;
                  bs   <= 1'b1;
                end
              end
              is_ff: begin
                addr <= '0;
                data <= SPACE;
              end
              default: ;
            endcase
          end
        end
        PUT: begin
          if (bus.wr_allow_i) begin
            if (bs) begin
              col <= col - 7'd1;
            end else if (col != LAST_COL) begin
              col <= col + 7'd1;
            end else begin
              col <= '0;
              if (row == LAST_ROW) begin
                row  <= '0;
                addr <= '0;
                data <= SPACE;
              end else begin
                row <= row + 5'd1;
              end
            end
          end
        end
        CLR_ROW: begin
          if (bus.wr_allow_i && a_col != LAST_COL)
            addr <= addr + 12'd1;
        end
        CLR_ALL: begin
          if (bus.wr_allow_i) begin
            if (a_col != LAST_COL) begin
              addr <= addr + 12'd1;
            end else if (a_row != LAST_ROW) begin
              addr <= {a_row + 5'd1, 7'd0};
            end else begin
              row <= '0;
              col <= '0;
            end
          end
        end
      endcase
    end
  end

  assign bus.wr_addr_o    = addr;
  assign bus.wr_data_o    = data;
  assign bus.cursor_col_o = col;
  assign bus.cursor_row_o = row;
endmodule
